// File: rtl/gray2bin_pipe_if.sv
// Valid/ready stream bundle for the pipelined Gray-to-binary decoder.
// master = upstream producer and downstream consumer side, slave = decoder side.
interface gray2bin_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_gray;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bin;
  logic             step_err;

  modport master (
    output in_valid, in_gray, out_ready,
    input  in_ready, out_valid, out_bin, step_err
  );

  modport slave (
    input  in_valid, in_gray, out_ready,
    output in_ready, out_valid, out_bin, step_err
  );
endinterface

// File: rtl/gray2bin_pipe.sv
// Pipelined Gray-to-binary decoder: STAGES-deep valid/ready pipeline, MSB-first slices per stage.
// Optional step check built when GRAY2BIN_STEP_CHECK_EN is defined (step_err tied 0 otherwise).
module gray2bin_pipe #(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  gray2bin_pipe_if.slave bus
);
  localparam int SLICE = (WIDTH + STAGES - 1) / STAGES;

  // Resolves the bits of slice s; bits above it are already binary, bits below stay Gray.
  function automatic logic [WIDTH-1:0] resolve_slice(input logic [WIDTH-1:0] w, input int s);
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] res;
    int               hi;
    int               lo;
    ones = '1;
    hi   = WIDTH - 1 - s * SLICE;
    lo   = WIDTH - (s + 1) * SLICE;
    if (lo < 0) lo = 0;
    mask = (ones >> (WIDTH - 1 - hi)) & (ones << lo);
    res  = w;
    for (int k = 0; k < SLICE; k++) begin
      res = (res & ~mask) | ((w ^ (res >> 1)) & mask);
    end
    return res;
  endfunction

  logic [STAGES-1:0] r_vld_p;
  logic [WIDTH-1:0]  r_data_p [STAGES];
  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_vin;
  logic [WIDTH-1:0]  w_din [STAGES];

  // A stage loads when it is empty or its successor is loading; bubbles collapse.
  always_comb begin
    logic ld;
    w_load = '0;
    ld     = !r_vld_p[STAGES-1] || bus.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      if (s != STAGES - 1) ld = !r_vld_p[s] || ld;
      w_load[s] = ld;
    end
  end

  assign w_vin[0] = bus.in_valid;
  assign w_din[0] = bus.in_gray;

  for (genvar g = 1; g < STAGES; g++) begin : g_link
    assign w_vin[g] = r_vld_p[g-1];
    assign w_din[g] = r_data_p[g-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
      for (int s = 0; s < STAGES; s++) r_data_p[s] <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_load[s]) begin
          r_vld_p[s] <= w_vin[s];
          if (w_vin[s]) r_data_p[s] <= resolve_slice(w_din[s], s);
        end
      end
    end
  end

  assign bus.in_ready  = w_load[0];
  assign bus.out_valid = r_vld_p[STAGES-1];
  assign bus.out_bin   = r_data_p[STAGES-1];

`ifdef GRAY2BIN_STEP_CHECK_EN
  function automatic logic step_too_large(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return $countones(a ^ b) > 1;
  endfunction

  logic [WIDTH-1:0]  r_prev_gray;
  logic              r_have_prev;
  logic [STAGES-1:0] r_err_p;
  logic [STAGES-1:0] w_ein;
  logic              w_accept;

  assign w_accept = bus.in_valid && w_load[0];
  assign w_ein[0] = r_have_prev && step_too_large(bus.in_gray, r_prev_gray);

  for (genvar g = 1; g < STAGES; g++) begin : g_err_link
    assign w_ein[g] = r_err_p[g-1];
  end

  // The flag rides the pipeline in lockstep with its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
      r_err_p     <= '0;
    end else begin
      if (w_accept) begin
        r_prev_gray <= bus.in_gray;
        r_have_prev <= 1'b1;
      end
      for (int s = 0; s < STAGES; s++) begin
        if (w_load[s] && w_vin[s]) r_err_p[s] <= w_ein[s];
      end
    end
  end

  assign bus.step_err = r_err_p[STAGES-1];
`else
  assign bus.step_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Self-checking bench for gray2bin_pipe: queue-based model plus directed literal checks.
module tb_gray2bin_pipe;
  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  gray2bin_pipe_if #(.WIDTH(W)) m  ();
  gray2bin_pipe_if #(.WIDTH(8)) m8 ();
  gray2bin_pipe_if #(.WIDTH(1)) m1 ();

  gray2bin_pipe #(.WIDTH(W), .STAGES(S)) dut   (.clk(clk), .rst_n(rst_n), .bus(m.slave));
  gray2bin_pipe #(.WIDTH(8), .STAGES(8)) dut_w8 (.clk(clk), .rst_n(rst_n), .bus(m8.slave));
  gray2bin_pipe #(.WIDTH(1), .STAGES(1)) dut_w1 (.clk(clk), .rst_n(rst_n), .bus(m1.slave));

  typedef struct {
    logic [W-1:0] bin;
    logic         err;
    int           acc_cyc;
    bit           seen;
  } exp_t;

  exp_t         q[$];
  exp_t         e;
  logic [W-1:0] obs_bin[$];
  logic         obs_err[$];
  int           cyc = 0;
  bit           exact_lat = 0;
  logic [W-1:0] prev_g = '0;
  bit           have_prev = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] model_g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: scoreboard against the model on every meaningful cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      have_prev = 0;
      chk("reset_out_valid", 32'(m.out_valid), 0);
      chk("reset_out_bin", 32'(m.out_bin), 0);
    end else begin
      if (m.out_valid) begin
        if (q.size() == 0) begin
          chk("out_valid_with_empty_model", 32'(m.out_valid), 0);
        end else begin
          chk("out_bin", 32'(m.out_bin), 32'(q[0].bin));
          chk("step_err", 32'(m.step_err), 32'(q[0].err));
          if (!q[0].seen) begin
            q[0].seen = 1;
            if (exact_lat) chk("latency", cyc - q[0].acc_cyc, S);
            else chk("latency_min", 32'(cyc - q[0].acc_cyc >= S), 1);
          end
          if (m.out_ready) begin
            obs_bin.push_back(m.out_bin);
            obs_err.push_back(m.step_err);
            void'(q.pop_front());
          end
        end
      end
      if (m.in_valid && m.in_ready) begin
        e.bin = model_g2b(m.in_gray);
`ifdef GRAY2BIN_STEP_CHECK_EN
        e.err = have_prev && ($countones(m.in_gray ^ prev_g) > 1);
`else
        e.err = 1'b0;
`endif
        e.acc_cyc = cyc;
        e.seen = 0;
        q.push_back(e);
        prev_g = m.in_gray;
        have_prev = 1;
      end
    end
  end

  task automatic cyc_drive(input logic v, input logic [W-1:0] g, input logic rdy, output logic acc);
    m.in_valid  = v;
    m.in_gray   = g;
    m.out_ready = rdy;
    @(negedge clk);
    acc = v && m.in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    int   n;
    n = 0;
    while ((q.size() != 0 || m.out_valid) && n < 100) begin
      cyc_drive(1'b0, '0, 1'b1, acc);
      n++;
    end
    chk("drain_model_empty", q.size(), 0);
    chk("drain_out_valid", 32'(m.out_valid), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    m.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic         acc;
    int           n;
    int           na;
    int           ncyc;
    logic [W-1:0] t5_g [4];
    logic [W-1:0] t5_b [4];
    logic         t5_e [4];

    rst_n = 1'b0;
    m.in_valid = 1'b0;  m.in_gray = '0;  m.out_ready = 1'b1;
    m8.in_valid = 1'b0; m8.in_gray = '0; m8.out_ready = 1'b1;
    m1.in_valid = 1'b0; m1.in_gray = '0; m1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(m.out_valid), 0);
    chk("rst_out_bin", 32'(m.out_bin), 0);
    chk("rst_step_err", 32'(m.step_err), 0);
    chk("rst_in_ready", 32'(m.in_ready), 1);
    chk("rst_w8_out_valid", 32'(m8.out_valid), 0);
    chk("rst_w1_out_valid", 32'(m1.out_valid), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1 sweep
    obs_bin.delete(); obs_err.delete();
    exact_lat = 1;
    for (int i = 0; i < 16; i++) begin
      cyc_drive(1'b1, b2g(W'(i)), 1'b1, acc);
      chk("t1_in_ready", 32'(acc), 1);
    end
    drain();
    exact_lat = 0;
    chk("t1_count", obs_bin.size(), 16);
    for (int i = 0; i < obs_bin.size() && i < 16; i++) chk("t1_order", 32'(obs_bin[i]), i);

    // T2 backpressure, then push+pop on a full pipe
    obs_bin.delete(); obs_err.delete();
    na = 0;
    for (int c = 0; c < 6; c++) begin
      cyc_drive(1'b1, b2g(W'(5 + na)), 1'b0, acc);
      if (acc) na++;
    end
    chk("t2_accepts", na, S);
    chk("t2_in_ready_low", 32'(m.in_ready), 0);
    chk("t2_out_bin_held", 32'(m.out_bin), 5);
    cyc_drive(1'b1, b2g(W'(7)), 1'b1, acc);
    chk("t2_full_push_pop", 32'(acc), 1);
    drain();
    chk("t2_count", obs_bin.size(), 3);
    for (int i = 0; i < obs_bin.size() && i < 3; i++) chk("t2_order", 32'(obs_bin[i]), 5 + i);

    // T3 random valid/ready
    na = 0;
    ncyc = 0;
    while (na < 1000 && ncyc < 20000) begin
      cyc_drive(1'($urandom_range(0, 1)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), acc);
      if (acc) na++;
      ncyc++;
    end
    chk("t3_words", na, 1000);
    drain();

    // T4 reset mid-stream
    cyc_drive(1'b1, b2g(W'(9)), 1'b0, acc);
    cyc_drive(1'b1, b2g(W'(10)), 1'b0, acc);
    chk("t4_in_flight", q.size(), 2);
    m.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t4_out_valid", 32'(m.out_valid), 0);
    chk("t4_out_bin", 32'(m.out_bin), 0);
    chk("t4_step_err", 32'(m.step_err), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_in_ready", 32'(m.in_ready), 1);
    chk("t4_out_valid_after", 32'(m.out_valid), 0);
    obs_bin.delete(); obs_err.delete();
    cyc_drive(1'b1, b2g(W'(11)), 1'b1, acc);
    cyc_drive(1'b1, b2g(W'(12)), 1'b1, acc);
    drain();
    chk("t4_count", obs_bin.size(), 2);
    if (obs_bin.size() == 2) begin
      chk("t4_first", 32'(obs_bin[0]), 11);
      chk("t4_second", 32'(obs_bin[1]), 12);
    end

    // T5 step check
    reset_pulse();
    t5_g = '{4'b0000, 4'b0001, 4'b0010, 4'b0010};
    t5_b = '{4'b0000, 4'b0001, 4'b0011, 4'b0011};
`ifdef GRAY2BIN_STEP_CHECK_EN
    t5_e = '{1'b0, 1'b0, 1'b1, 1'b0};
`else
    t5_e = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
    obs_bin.delete(); obs_err.delete();
    exact_lat = 1;
    for (int i = 0; i < 4; i++) cyc_drive(1'b1, t5_g[i], 1'b1, acc);
    drain();
    exact_lat = 0;
    chk("t5_count", obs_bin.size(), 4);
    for (int i = 0; i < obs_bin.size() && i < 4; i++) begin
      chk("t5_out_bin", 32'(obs_bin[i]), 32'(t5_b[i]));
      chk("t5_step_err", 32'(obs_err[i]), 32'(t5_e[i]));
    end

    // T6 edges: WIDTH=8/STAGES=8 and WIDTH=1/STAGES=1
    m8.in_valid = 1'b1; m8.in_gray = 8'h80; m8.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_w8_in_ready", 32'(m8.in_ready), 1);
    @(posedge clk);
    #1;
    m8.in_valid = 1'b0;
    n = 1;
    while (!m8.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_w8_latency", n, 8);
    chk("t6_w8_out_bin", 32'(m8.out_bin), 32'hFF);

    m1.in_valid = 1'b1; m1.in_gray = 1'b1; m1.out_ready = 1'b1;
    @(negedge clk);
    chk("t6_w1_in_ready", 32'(m1.in_ready), 1);
    @(posedge clk);
    #1;
    m1.in_valid = 1'b0;
    n = 1;
    while (!m1.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("t6_w1_latency", n, 1);
    chk("t6_w1_out_bin", 32'(m1.out_bin), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
